// File: rtl/asyn_fifo_rd_drain.sv
// Read-side drain for the async FIFO: credit-gated rinc, one-cycle rdata capture, 2-entry skid buffer to a valid/ready stream.
// Optional counters rd_count / stall_cycles are built only when ASYN_FIFO_RD_STATS_EN is defined.
module asyn_fifo_rd_drain #(
  parameter int DSIZE     = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic             busy
`ifdef ASYN_FIFO_RD_STATS_EN
  ,
  output logic [31:0]      rd_count,
  output logic [15:0]      stall_cycles
`endif
);

  // state | meaning
  // IDLE  | draining disabled, no read in flight
  // RUN   | rinc may be issued when the FIFO has data and credits remain
  // STOP  | en dropped; wait for any in-flight word before going idle
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

  state_t           state, state_nxt;
  logic [1:0]       occ, occ_nxt;
  logic             infl;
  logic             rd_ptr, wr_ptr;
  logic [DSIZE-1:0] mem [2];
  logic             pop;
  logic             credit_ok;

  assign pop     = m_valid && m_ready;
  assign m_valid = (occ != 2'd0);
  assign m_data  = mem[rd_ptr];
  assign busy    = (state != IDLE) || (occ != 2'd0);

  // A word leaving this cycle frees its slot for a read issued now; this is the m_ready->rinc path.
  assign credit_ok = ({1'b0, occ} + {2'b00, infl}) < (DEPTH + {2'b00, pop});
  assign rinc      = (state == RUN) && !rempty && !rrst && credit_ok;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = STOP;
      STOP:    if (!infl) state_nxt = en ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    occ_nxt = occ;
    case ({infl, pop})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state  <= IDLE;
      occ    <= 2'd0;
      infl   <= 1'b0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      occ   <= occ_nxt;
      infl  <= rinc;
      if (infl) begin
        mem[wr_ptr] <= rdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

`ifdef ASYN_FIFO_RD_STATS_EN
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rd_count     <= 32'd0;
      stall_cycles <= 16'd0;
    end else begin
      if (pop) rd_count <= rd_count + 32'd1;
      if (m_valid && !m_ready && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
